// File: rtl/srlatch_responder.sv
// Clocked 4-phase set/reset responder: synchronizes s/r, updates q, drives ack, flags violations on err.
// Optional macro SRLATCH_RESPONDER_COUNT_EN adds an 8-bit completed-handshake counter output txn_count.
module srlatch_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_DELAY   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s,
  input  logic       r,
  output logic       q,
  output logic       ack,
  output logic       err
`ifdef SRLATCH_RESPONDER_COUNT_EN
  ,
  output logic [7:0] txn_count
`endif
);

  typedef enum logic [2:0] {IDLE, SETTLE, ACK, RTZ, VIOL} state_t;

  // SETTLE counts down to zero inclusive, so one less than the delay makes ack land on E0+SYNC+DELAY
  localparam logic [3:0] SETTLE_LOAD = (ACK_DELAY > 0) ? 4'(ACK_DELAY - 1) : 4'd0;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] s_sync, r_sync;
  logic                   ss, rs;
  logic [3:0]             cnt, cnt_next;
  logic                   req, req_next;
  logic                   q_next, ack_next, err_next;

  assign ss = s_sync[SYNC_STAGES-1];
  assign rs = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_sync <= '0;
      r_sync <= '0;
      state  <= IDLE;
      cnt    <= 4'd0;
      req    <= 1'b0;
      q      <= 1'b0;
      ack    <= 1'b0;
      err    <= 1'b0;
    end else begin
      s_sync <= {s_sync[SYNC_STAGES-2:0], s};
      r_sync <= {r_sync[SYNC_STAGES-2:0], r};
      state  <= state_next;
      cnt    <= cnt_next;
      req    <= req_next;
      q      <= q_next;
      ack    <= ack_next;
      err    <= err_next;
    end
  end

  // req holds which line opened the handshake (1 = set); ack drops as RTZ is left
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    req_next   = req;
    q_next     = q;
    ack_next   = ack;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (ss && rs) begin
          state_next = VIOL;
          err_next   = 1'b1;
          ack_next   = 1'b0;
        end else if (ss ^ rs) begin
          req_next = ss;
          if (ACK_DELAY == 0) begin
            state_next = ACK;
            ack_next   = 1'b1;
            q_next     = ss;
          end else begin
            state_next = SETTLE;
            cnt_next   = SETTLE_LOAD;
          end
        end
      end
      SETTLE: begin
        if (!ss && !rs) begin
          state_next = IDLE;
        end else if (ss && rs) begin
          state_next = VIOL;
          err_next   = 1'b1;
          ack_next   = 1'b0;
        end else if (cnt == 4'd0) begin
          state_next = ACK;
          ack_next   = 1'b1;
          q_next     = req;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      ACK: begin
        if (req ? rs : ss) begin
          state_next = VIOL;
          err_next   = 1'b1;
          ack_next   = 1'b0;
        end else if (!ss && !rs) begin
          state_next = RTZ;
        end
      end
      RTZ: begin
        ack_next   = 1'b0;
        state_next = IDLE;
      end
      VIOL: begin
        if (!ss && !rs) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        ack_next   = 1'b0;
      end
    endcase
  end

`ifdef SRLATCH_RESPONDER_COUNT_EN
  // Only ACK->RTZ is a completed handshake; aborts and violations never pass this way
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) txn_count <= 8'd0;
    else if (state == ACK && state_next == RTZ) txn_count <= txn_count + 8'd1;
  end
`endif

endmodule
